// File: rtl/led_stream_mask.sv
`timescale 1ns/1ps
// Serial LED stream decoder: locks on a sync nibble, parses a frame header and
// gates the LED shift clock onto the payload bits that belong to this module.
module led_stream_mask #(
  parameter int unsigned CH       = 1,
  parameter int unsigned ADDR_W   = 4,
  parameter int unsigned SEG_BITS = 4,
  parameter int unsigned LINES    = 4,
  parameter int unsigned ROW_W    = 6,
  parameter logic [3:0]  SYNC     = 4'hA
) (
  input  logic              i2s_clk,
  input  logic              rst_n,
  input  logic [CH-1:0]     i2s_data,
  input  logic [ADDR_W-1:0] addr_x,
  input  logic [ADDR_W-1:0] addr_y,
  output logic [CH-1:0]     led_data,
  output logic              led_clk,
  output logic              led_lat,
  output logic              led_oe,
  output logic [ROW_W-1:0]  row_num,
  output logic              hdr_err
);

  localparam int unsigned SEG_LINES = SEG_BITS * LINES;
  localparam int unsigned IDX_W     = 2 * ADDR_W + $clog2(SEG_LINES);
  localparam int unsigned LEN_W     = IDX_W + 1;
  localparam int unsigned HDR_W     = 2 * ADDR_W + ROW_W + 1;
  localparam int unsigned HCNT_W    = $clog2(HDR_W);
  localparam int unsigned SEG_W     = (SEG_BITS > 1) ? $clog2(SEG_BITS) : 1;
  localparam int unsigned LINE_W    = (LINES > 1) ? $clog2(LINES) : 1;

  typedef enum logic [1:0] {HUNT, HEADER, PAYLOAD, LATCH} state_t;

  state_t              state, state_nxt;
  logic [3:0]          sync_sr;
  logic [HDR_W-1:0]    hdr;
  logic [HCNT_W-1:0]   hdr_cnt;
  logic [IDX_W-1:0]    idx, idx_last;
  logic [SEG_W-1:0]    seg_cnt;
  logic [ADDR_W-1:0]   col_cnt, yrow_cnt;
  logic [LINE_W-1:0]   line_cnt;
  logic                addressed;
  logic                clk_en;

  logic [3:0]          sync_c;
  logic                sync_hit_c;
  logic [HDR_W-1:0]    hdr_full_c;
  logic [ADDR_W-1:0]   nx_c, ny_c, nx_m1;
  logic [ROW_W-1:0]    row_hdr;
  logic [LEN_W-1:0]    len_c;
  logic                hdr_done_c, par_ok_c, addr_ok_c, frame_end_c, owned_c;
  logic                lat_set_c, err_set_c, blank_c;

  assign led_data = i2s_data;
  assign led_clk  = i2s_clk & clk_en;

  // Header decode works on the word including the bit arriving this cycle.
  assign sync_c      = {sync_sr[2:0], i2s_data[0]};
  assign sync_hit_c  = (sync_c == SYNC);
  assign hdr_full_c  = {hdr[HDR_W-2:0], i2s_data[0]};
  assign nx_c        = hdr_full_c[HDR_W-1 -: ADDR_W];
  assign ny_c        = hdr_full_c[HDR_W-1-ADDR_W -: ADDR_W];
  assign par_ok_c    = (hdr_full_c[0] == ^hdr_full_c[HDR_W-1:1]);
  assign addr_ok_c   = (addr_x <= nx_c) && (addr_y <= ny_c);
  assign hdr_done_c  = (state == HEADER) && (hdr_cnt == HCNT_W'(HDR_W - 1));
  assign len_c       = (LEN_W'(nx_c) + LEN_W'(1)) * (LEN_W'(ny_c) + LEN_W'(1)) * LEN_W'(SEG_LINES);

  assign nx_m1       = hdr[HDR_W-1 -: ADDR_W];
  assign row_hdr     = hdr[ROW_W:1];
  assign frame_end_c = (idx == idx_last);
  assign owned_c     = (state == PAYLOAD) && addressed &&
                       (col_cnt == addr_x) && (yrow_cnt == addr_y);

  always_ff @(posedge i2s_clk or negedge rst_n) begin
    if (!rst_n) state <= HUNT;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    lat_set_c = 1'b0;
    err_set_c = 1'b0;
    blank_c   = 1'b0;
    case (state)
      HUNT:    if (sync_hit_c) state_nxt = HEADER;
      HEADER: begin
        if (hdr_done_c) begin
          if (!par_ok_c) begin
            state_nxt = HUNT;
            err_set_c = 1'b1;
          end else begin
            state_nxt = PAYLOAD;
            blank_c   = !addr_ok_c;
          end
        end
      end
      PAYLOAD: begin
        if (frame_end_c) begin
          state_nxt = addressed ? LATCH : HUNT;
          lat_set_c = addressed;
        end
      end
      LATCH:   state_nxt = HUNT;
      default: state_nxt = HUNT;
    endcase
  end

  // Datapath: sync/header shifters, payload index and module-position counters.
  always_ff @(posedge i2s_clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_sr   <= '0;
      hdr       <= '0;
      hdr_cnt   <= '0;
      idx       <= '0;
      idx_last  <= '0;
      seg_cnt   <= '0;
      col_cnt   <= '0;
      line_cnt  <= '0;
      yrow_cnt  <= '0;
      addressed <= 1'b0;
      led_lat   <= 1'b0;
      hdr_err   <= 1'b0;
      led_oe    <= 1'b1;
      row_num   <= '0;
    end else begin
      sync_sr <= ((state == HUNT) && !sync_hit_c) ? sync_c : 4'h0;
      led_lat <= lat_set_c;
      hdr_err <= err_set_c;

      if (state == HUNT) hdr_cnt <= '0;
      if (state == HEADER) begin
        hdr     <= hdr_full_c;
        hdr_cnt <= hdr_cnt + HCNT_W'(1);
      end

      if (hdr_done_c) begin
        idx_last  <= IDX_W'(len_c - LEN_W'(1));
        addressed <= addr_ok_c;
        idx       <= '0;
        seg_cnt   <= '0;
        col_cnt   <= '0;
        line_cnt  <= '0;
        yrow_cnt  <= '0;
      end

      // Index order: bit in segment, module column, line, module row.
      if ((state == PAYLOAD) && !frame_end_c) begin
        idx <= idx + IDX_W'(1);
        if (seg_cnt == SEG_W'(SEG_BITS - 1)) begin
          seg_cnt <= '0;
          if (col_cnt == nx_m1) begin
            col_cnt <= '0;
            if (line_cnt == LINE_W'(LINES - 1)) begin
              line_cnt <= '0;
              yrow_cnt <= yrow_cnt + ADDR_W'(1);
            end else begin
              line_cnt <= line_cnt + LINE_W'(1);
            end
          end else begin
            col_cnt <= col_cnt + ADDR_W'(1);
          end
        end else begin
          seg_cnt <= seg_cnt + SEG_W'(1);
        end
      end

      if (lat_set_c) row_num <= row_hdr;

      if (err_set_c || blank_c || lat_set_c) led_oe <= 1'b1;
      else if (state == LATCH)               led_oe <= 1'b0;
    end
  end

  // Clock enable changes only while i2s_clk is low so the gated clock is clean.
  always_ff @(negedge i2s_clk or negedge rst_n) begin
    if (!rst_n) clk_en <= 1'b0;
    else        clk_en <= owned_c;
  end

endmodule

// File: tb/tb_led_stream_mask.sv
`timescale 1ns/1ps
// Randomised bench for led_stream_mask: two instances (1 and 3 lanes) share one
// stream and are scored against a window/ownership model of each frame.
module tb_led_stream_mask;

  localparam int unsigned ADDR_W   = 4;
  localparam int unsigned SEG_BITS = 4;
  localparam int unsigned LINES    = 4;
  localparam int unsigned ROW_W    = 6;
  localparam int unsigned HDR_W    = 2 * ADDR_W + ROW_W + 1;

  logic i2s_clk = 1'b0;
  logic rst_n;
  logic [2:0] din;
  logic [ADDR_W-1:0] ax_a, ay_a, ax_b, ay_b;

  logic [0:0]       led_data_a;
  logic             led_clk_a, led_lat_a, led_oe_a, hdr_err_a;
  logic [ROW_W-1:0] row_a;
  logic [2:0]       led_data_b;
  logic             led_clk_b, led_lat_b, led_oe_b, hdr_err_b;
  logic [ROW_W-1:0] row_b;

  always #5 i2s_clk = ~i2s_clk;

  led_stream_mask u_dut_a (
    .i2s_clk (i2s_clk), .rst_n (rst_n), .i2s_data (din[0:0]),
    .addr_x (ax_a), .addr_y (ay_a),
    .led_data (led_data_a), .led_clk (led_clk_a), .led_lat (led_lat_a),
    .led_oe (led_oe_a), .row_num (row_a), .hdr_err (hdr_err_a)
  );

  led_stream_mask #(.CH(3)) u_dut_b (
    .i2s_clk (i2s_clk), .rst_n (rst_n), .i2s_data (din),
    .addr_x (ax_b), .addr_y (ay_b),
    .led_data (led_data_b), .led_clk (led_clk_b), .led_lat (led_lat_b),
    .led_oe (led_oe_b), .row_num (row_b), .hdr_err (hdr_err_b)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cur_idx = -1;
  logic [2:0] pay [0:4095];
  int edges_a, edges_b, lat_a, lat_b, herr_a, herr_b, data_bad;
  int unsigned hash_a, hash_b;
  int exp_row_a = 0;
  int exp_row_b = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Shift-clock edges log which payload bit was presented and the data shifted.
  always @(posedge led_clk_a) begin
    edges_a++;
    hash_a = hash_a * 33 + 32'(cur_idx) * 8 + 32'(led_data_a);
  end
  always @(posedge led_clk_b) begin
    edges_b++;
    hash_b = hash_b * 33 + 32'(cur_idx) * 8 + 32'(led_data_b);
  end
  always @(negedge i2s_clk) begin
    lat_a  += 32'(led_lat_a);
    lat_b  += 32'(led_lat_b);
    herr_a += 32'(hdr_err_a);
    herr_b += 32'(hdr_err_b);
  end
  always @(posedge i2s_clk) begin
    if (led_data_a !== din[0:0] || led_data_b !== din) data_bad++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic clear_mon();
    edges_a = 0; edges_b = 0; hash_a = 0; hash_b = 0;
    lat_a = 0; lat_b = 0; herr_a = 0; herr_b = 0; data_bad = 0;
  endtask

  task automatic send(input logic [2:0] v, input int idx);
    @(negedge i2s_clk);
    din = v;
    cur_idx = idx;
  endtask

  task automatic send_bit(input logic b);
    send({2'($urandom), b}, -1);
  endtask

  task automatic send_header(input int nx, input int ny, input int rw, input bit bad);
    logic [ADDR_W-1:0] nxv, nyv;
    logic [ROW_W-1:0]  rv;
    logic [HDR_W-1:0]  h;
    logic [3:0]        s;
    nxv = ADDR_W'(nx); nyv = ADDR_W'(ny); rv = ROW_W'(rw);
    s = 4'hA;
    for (int i = 3; i >= 0; i--) send_bit(s[i]);
    h = {nxv, nyv, rv, (^{nxv, nyv, rv}) ^ bad};
    for (int i = HDR_W - 1; i >= 0; i--) send_bit(h[i]);
  endtask

  function automatic bit owns(input int idx, input int nx, input int ax, input int ay);
    for (int i = 0; i < LINES; i++) begin
      int s;
      s = SEG_BITS * ((ay * LINES + i) * (nx + 1) + ax);
      if (idx >= s && idx < s + SEG_BITS) return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic check_dut(input string tag, input int edges, input int unsigned hash,
                           input int lat, input int herr, input logic [ROW_W-1:0] row,
                           input logic oe, input int nx, input int ny, input int ax,
                           input int ay, input int rw, input bit bad, input bit wide,
                           inout int exp_row);
    bit live;
    int n, cnt;
    int unsigned h;
    live = (ax <= nx) && (ay <= ny) && !bad;
    n = (nx + 1) * (ny + 1) * SEG_BITS * LINES;
    cnt = 0;
    h = 0;
    if (live) begin
      for (int i = 0; i < n; i++) begin
        if (owns(i, nx, ax, ay)) begin
          cnt++;
          h = h * 33 + 32'(i) * 8 + (wide ? 32'(pay[i]) : 32'(pay[i][0]));
        end
      end
      exp_row = rw;
    end
    check({tag, "_edges"}, 32'(edges), 32'(cnt));
    check({tag, "_shift"}, hash, h);
    check({tag, "_lat"},   32'(lat),  live ? 32'd1 : 32'd0);
    check({tag, "_herr"},  32'(herr), bad ? 32'd1 : 32'd0);
    check({tag, "_row"},   32'(row),  32'(exp_row));
    check({tag, "_oe"},    32'(oe),   live ? 32'd0 : 32'd1);
  endtask

  task automatic run_frame(input string tag, input int nx, input int ny, input int rw,
                           input bit bad, input bit garbage);
    logic [7:0] g;
    int n;
    clear_mon();
    g = 8'b0110_1100;
    if (garbage) for (int i = 7; i >= 0; i--) send_bit(g[i]);
    send_header(nx, ny, rw, bad);
    if (!bad) begin
      n = (nx + 1) * (ny + 1) * SEG_BITS * LINES;
      for (int i = 0; i < n; i++) begin
        pay[i] = 3'($urandom);
        send(pay[i], i);
      end
    end
    repeat (3) send_bit(1'b0);
    check_dut({tag, "_a"}, edges_a, hash_a, lat_a, herr_a, row_a, led_oe_a,
              nx, ny, int'(ax_a), int'(ay_a), rw, bad, 1'b0, exp_row_a);
    check_dut({tag, "_b"}, edges_b, hash_b, lat_b, herr_b, row_b, led_oe_b,
              nx, ny, int'(ax_b), int'(ay_b), rw, bad, 1'b1, exp_row_b);
    check({tag, "_leddata"}, 32'(data_bad), 32'd0);
  endtask

  task automatic set_addr(input int xa, input int ya, input int xb, input int yb);
    ax_a = ADDR_W'(xa); ay_a = ADDR_W'(ya);
    ax_b = ADDR_W'(xb); ay_b = ADDR_W'(yb);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_oe_a"},   32'(led_oe_a),  32'd1);
    check({tag, "_lat_a"},  32'(led_lat_a), 32'd0);
    check({tag, "_herr_a"}, 32'(hdr_err_a), 32'd0);
    check({tag, "_row_a"},  32'(row_a),     32'd0);
    check({tag, "_clk_a"},  32'(led_clk_a), 32'd0);
    check({tag, "_oe_b"},   32'(led_oe_b),  32'd1);
    check({tag, "_row_b"},  32'(row_b),     32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    din = 3'b000;
    set_addr(1, 0, 0, 1);
    clear_mon();
    repeat (2) @(negedge i2s_clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;

    run_frame("addressed", 1, 0, 5, 1'b0, 1'b0);
    run_frame("parity",    1, 0, 5, 1'b1, 1'b0);
    run_frame("after_par", 1, 0, 5, 1'b0, 1'b0);
    set_addr(2, 0, 0, 1);
    run_frame("unaddr",    1, 0, 12, 1'b0, 1'b0);
    set_addr(1, 0, 0, 1);
    run_frame("hunt",      1, 0, 5, 1'b0, 1'b1);
    set_addr(0, 0, 0, 1);
    run_frame("multilane", 0, 1, 33, 1'b0, 1'b0);
    set_addr(0, 0, 0, 0);
    run_frame("min_frame", 0, 0, 63, 1'b0, 1'b0);

    // Reset in the middle of a payload, at index 10.
    set_addr(1, 0, 0, 1);
    run_frame("pre_rst", 1, 1, 9, 1'b0, 1'b0);
    clear_mon();
    send_header(1, 1, 21, 1'b0);
    for (int i = 0; i <= 10; i++) begin
      pay[i] = 3'($urandom);
      send(pay[i], i);
    end
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("midrst");
    repeat (2) @(negedge i2s_clk);
    rst_n = 1'b1;
    exp_row_a = 0;
    exp_row_b = 0;
    check("midrst_nolat", 32'(lat_a + lat_b), 32'd0);
    clear_mon();
    for (int i = 11; i < 20; i++) send_bit(1'b0);
    check("postrst_edges", 32'(edges_a + edges_b), 32'd0);
    check("postrst_oe", 32'(led_oe_a), 32'd1);
    run_frame("after_rst", 1, 1, 21, 1'b0, 1'b0);

    set_addr(15, 15, int'($urandom_range(15)), int'($urandom_range(15)));
    run_frame("max_frame", 15, 15, 42, 1'b0, 1'b0);

    for (int k = 0; k < 10; k++) begin
      int nx, ny;
      nx = int'($urandom_range(3));
      ny = int'($urandom_range(3));
      set_addr(int'($urandom_range(4)), int'($urandom_range(4)),
               int'($urandom_range(4)), int'($urandom_range(4)));
      run_frame($sformatf("rand%0d", k), nx, ny, int'($urandom_range(63)),
                ($urandom_range(4) == 0), ($urandom_range(1) == 1));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/led_stream_mask.md
LED_STREAM_MASK -- requirements
Module: led_stream_mask

Interface
REQ-001 Parameters (name, default, meaning) SHALL be:
 - CH, 1, parallel data lanes.
 - ADDR_W, 4, module-coordinate width.
 - SEG_BITS, 4, bits per module per line.
 - LINES, 4, lines per module.
 - ROW_W, 6, row-number width.
 - SYNC, 4'hA, header sync nibble.
REQ-002 Ports (name, direction, width, meaning) SHALL be:
 - i2s_clk, in, 1, stream clock.
 - rst_n, in, 1, reset; asynchronous, active-low.
 - i2s_data, in, CH, serial data; lane 0 carries the header.
 - addr_x / addr_y, in, ADDR_W each, this module's position.
 - led_data, out, CH, data to the LED drivers.
 - led_clk, out, 1, gated shift clock.
 - led_lat, out, 1, latch pulse.
 - led_oe, out, 1, output enable, active-low.
 - row_num, out, ROW_W, current row.
 - hdr_err, out, 1, header-error pulse.
REQ-003 IDX_W SHALL equal 2*ADDR_W + clog2(SEG_BITS*LINES), which is 12 at defaults.

Function
REQ-004 led_data SHALL be a combinational copy of i2s_data on all lanes.
REQ-005 led_clk SHALL equal i2s_clk AND clk_en; clk_en SHALL be registered on the falling edge of i2s_clk so led_clk never glitches.
REQ-006 The FSM SHALL have states HUNT, HEADER, PAYLOAD, LATCH; every other register SHALL update on the rising edge of i2s_clk.
REQ-007 HUNT: the last 4 lane-0 bits SHALL be shifted in, and a match to SYNC SHALL move the FSM to HEADER with the bit counter at 0.
REQ-008 HEADER SHALL capture 2*ADDR_W+ROW_W+1 lane-0 bits, MSB first, as nx_m1, ny_m1, row, par.
REQ-009 At the end of HEADER, if par differs from the XOR of nx_m1, ny_m1 and row, then hdr_err SHALL be 1 for exactly one cycle and the FSM SHALL return to HUNT; otherwise the FSM SHALL go to PAYLOAD with index 0.
REQ-010 The frame length SHALL be N = (nx_m1+1)*(ny_m1+1)*SEG_BITS*LINES payload bits, and index SHALL count 0..N-1 at full IDX_W width with no truncation.
REQ-011 For line i in 0..LINES-1, the owned window SHALL start at S_i = SEG_BITS*((addr_y*LINES+i)*(nx_m1+1)+addr_x) and span SEG_BITS bits.
REQ-012 clk_en SHALL be high during the high phase of i2s_clk for exactly the owned payload bits, giving exactly SEG_BITS*LINES led_clk rising edges per valid frame; clk_en SHALL be 0 outside PAYLOAD.
REQ-013 The module SHALL be unaddressed when addr_x > nx_m1 or addr_y > ny_m1; an unaddressed frame SHALL produce no led_clk edges and no led_lat, and SHALL drive led_oe to 1.
REQ-014 On index N-1 the FSM SHALL go to LATCH; in LATCH (one cycle) led_lat SHALL be 1, row_num SHALL load row, and led_oe SHALL be 1 (blank); the FSM SHALL then return to HUNT.
REQ-015 led_oe SHALL be 0 from the cycle after the first LATCH until the next LATCH, header error, or unaddressed frame.
REQ-016 Sync bits arriving in PAYLOAD SHALL be ignored; payload is never re-synchronised mid-frame.
REQ-017 The minimum frame (nx_m1=ny_m1=0) and the maximum frame (N = 2^IDX_W) SHALL both be handled without index wrap.

Reset
REQ-018 While rst_n is 0:
 - FSM SHALL be in HUNT.
 - index, header and sync shift register SHALL be 0.
 - clk_en, led_lat, hdr_err SHALL be 0.
 - row_num SHALL be 0.
 - led_oe SHALL be 1.
REQ-019 Reset asserted mid-frame SHALL abort the frame with no led_lat, and after release the block SHALL require a new SYNC before any output activity.

Verification
REQ-020 Addressed frame: defaults, addr=(1,0), header nx_m1=1, ny_m1=0, row=5, correct par, N=32 -> led_clk edges on indices 4-7, 12-15, 20-23, 28-31 (16 total); then led_lat for 1 cycle, row_num=5, led_oe=0 afterwards.
REQ-021 Parity error: same header with par inverted -> hdr_err 1 cycle, 0 led_clk edges, no led_lat, row_num unchanged; the next good frame behaves as in REQ-020.
REQ-022 Unaddressed: addr=(2,0), nx_m1=1 -> 0 led_clk edges, no led_lat, led_oe=1.
REQ-023 Hunt: 0110_1100 garbage then SYNC then a valid header -> lock occurs on SYNC, and the frame behaves as in REQ-020.
REQ-024 Reset at payload index 10 -> all outputs at reset values within the reset-assertion delay; no led_lat; the next full frame is correct.
REQ-025 Multi-lane: CH=3, addr=(0,1), nx_m1=0, ny_m1=1, N=32 -> 16 led_clk edges on indices 16-31, and led_data equals i2s_data on all three lanes throughout.
